// File: rtl/universal_register_n.sv
// universal_register_n: WIDTH-bit storage element with parallel load, shift,
// rotate, increment and decrement.
// Q, Qn and CO update on the rising edge of CLK. RST is active-low and
// clears the register immediately, without waiting for a clock edge.
// Qn and ZERO are derived combinationally from the stored word.
module universal_register_n #(
    parameter int unsigned           WIDTH       = 8,
    parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic [2:0]       MODE,
    input  logic [WIDTH-1:0] D,
    input  logic             SIR,
    input  logic             SIL,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qn,
    output logic             CO,
    output logic             ZERO
);

    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_LOAD = 3'b001,
        MODE_SHR  = 3'b010,
        MODE_SHL  = 3'b011,
        MODE_ROR  = 3'b100,
        MODE_ROL  = 3'b101,
        MODE_INC  = 3'b110,
        MODE_DEC  = 3'b111
    } mode_t;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_q;
    logic             r_co;
    logic [WIDTH-1:0] w_q_next;
    logic             w_co_next;

    // Next-state selection; EN low keeps the current word and flag.
    always_comb begin
        w_q_next  = r_q;
        w_co_next = r_co;
        if (EN) begin
            unique case (mode_t'(MODE))
                MODE_HOLD: begin
                    w_q_next  = r_q;
                    w_co_next = r_co;
                end
                MODE_LOAD: begin
                    w_q_next  = D;
                    w_co_next = 1'b0;
                end
                MODE_SHR: begin
                    w_q_next  = {SIR, r_q[WIDTH-1:1]};
                    w_co_next = r_q[0];
                end
                MODE_SHL: begin
                    w_q_next  = {r_q[WIDTH-2:0], SIL};
                    w_co_next = r_q[WIDTH-1];
                end
                MODE_ROR: begin
                    w_q_next  = {r_q[0], r_q[WIDTH-1:1]};
                    w_co_next = r_q[0];
                end
                MODE_ROL: begin
                    w_q_next  = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
                    w_co_next = r_q[WIDTH-1];
                end
                MODE_INC: begin
                    w_q_next  = r_q + ONE;
                    w_co_next = &r_q;
                end
                MODE_DEC: begin
                    w_q_next  = r_q - ONE;
                    w_co_next = ~|r_q;
                end
            endcase
        end
    end

    // State register with asynchronous active-low clear to RESET_VALUE.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_q  <= RESET_VALUE;
            r_co <= 1'b0;
        end else begin
            r_q  <= w_q_next;
            r_co <= w_co_next;
        end
    end

    assign Q    = r_q;
    assign Qn   = ~r_q;
    assign CO   = r_co;
    assign ZERO = (r_q == '0);

endmodule
